// File: rtl/sub_64_serial_pkg.sv
// Shared definitions for the digit-serial subtractor: state encoding and
// elaboration-time helpers for slice count and counter width.
package sub_64_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_n(input int width, input int digit_w);
        return width / digit_w;
    endfunction

    // A single-slice configuration still needs a 1-bit counter to exist.
    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit legal_digit(input int width, input int digit_w);
        bit ok;
        case (digit_w)
            1, 2, 4, 8, 16, 32, 64: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok && (width % digit_w == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared across the datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sub_64_serial_slice.sv
// Combinational DIGIT_W-bit ripple slice computing a_s + ~b_s + cin; also
// exposes the carry into the slice's top bit for overflow detection.
module sub_slice #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a_s,
    input  logic [DIGIT_W-1:0] b_s,
    input  logic               cin,
    output logic [DIGIT_W-1:0] d_s,
    output logic               cout,
    output logic               c_msb
);

    logic [DIGIT_W:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
        full_adder u_fa (
            .a    (a_s[i]),
            .b    (~b_s[i]),
            .cin  (c_s[i]),
            .s    (d_s[i]),
            .cout (c_s[i+1])
        );
    end

    assign cout  = c_s[DIGIT_W];
    assign c_msb = c_s[DIGIT_W-1];

endmodule

// File: rtl/sub_64_serial.sv
// Digit-serial two's-complement subtractor (a - b), DIGIT_W bits per clock,
// LSB first, with start/busy/done handshake and borrow/overflow flags.
module sub_64_serial
    import sub_64_serial_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int N     = calc_n(WIDTH, DIGIT_W);
    localparam int CNT_W = calc_cnt_w(N);

    if (!legal_digit(WIDTH, DIGIT_W)) begin : g_bad_digit
        $error("sub_64_serial: DIGIT_W=%0d is illegal for WIDTH=%0d", DIGIT_W, WIDTH);
    end

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   acc_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic [DIGIT_W-1:0] d_s;
    logic               cout_s;
    logic               c_msb_s;
    logic               load_s;
    logic               step_s;
    logic               last_s;

    sub_slice #(.DIGIT_W(DIGIT_W)) u_slice (
        .a_s   (a_sh_r[DIGIT_W-1:0]),
        .b_s   (b_sh_r[DIGIT_W-1:0]),
        .cin   (carry_r),
        .d_s   (d_s),
        .cout  (cout_s),
        .c_msb (c_msb_s)
    );

    // Each new slice enters at the top so the LSB slice lands at bit 0 after N steps.
    assign acc_next_s = (acc_r >> DIGIT_W) | (WIDTH'(d_s) << (WIDTH - DIGIT_W));

    // Next-state and control decode.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = (cnt_r == CNT_W'(N - 1));
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == RUN);
            done    <= (state_s == DONE);
        end
    end

    // Operand shifters, running carry and result/flag capture; the visible
    // result only changes on the final slice so partial sums never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (load_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            cnt_r   <= '0;
            carry_r <= 1'b1;
        end else if (step_s) begin
            a_sh_r  <= a_sh_r >> DIGIT_W;
            b_sh_r  <= b_sh_r >> DIGIT_W;
            acc_r   <= acc_next_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            carry_r <= cout_s;
            if (last_s) begin
                diff     <= acc_next_s;
                borrow   <= ~cout_s;
                overflow <= c_msb_s ^ cout_s;
            end
        end
    end

endmodule

// File: tb/tb_sub_64_serial.sv
// Directed bench for sub_64_serial: a bit-serial (DIGIT_W=1) and a byte-serial
// (DIGIT_W=8) instance, table-driven vectors plus handshake and reset sequences.
module tb_sub_64_serial;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        start1, start8;
    logic        busy1, done1, borrow1, ovf1;
    logic        busy8, done8, borrow8, ovf8;
    logic [63:0] diff1, diff8;

    int errors;
    int checks;
    logic [63:0] prev1, prev8;

    typedef struct {
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] d;
        logic        bor;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    sub_64_serial #(.WIDTH(64), .DIGIT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .overflow(ovf1)
    );

    sub_64_serial #(.WIDTH(64), .DIGIT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] o_diff(input int sel);
        return (sel == 1) ? diff1 : diff8;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel == 1) ? busy1 : busy8;
    endfunction
    function automatic logic o_done(input int sel);
        return (sel == 1) ? done1 : done8;
    endfunction
    function automatic logic o_bor(input int sel);
        return (sel == 1) ? borrow1 : borrow8;
    endfunction
    function automatic logic o_ovf(input int sel);
        return (sel == 1) ? ovf1 : ovf8;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else          start8 = v;
    endtask

    // Waits (bounded) for done after an accept edge; checks latency, busy span,
    // result hold during RUN and the result/flags in the done cycle.
    task automatic wait_done(input int sel, input int n, input logic [63:0] prev,
                             input logic [63:0] ed, input logic eb, input logic eo);
        int busy_cnt;
        int lat;
        busy_cnt = 0;
        lat      = -1;
        for (int c = 0; c <= n + 4; c++) begin
            @(negedge clk);
            if (o_busy(sel)) busy_cnt++;
            if (c == n / 2 && c < n) begin
                chk("hold_diff", o_diff(sel), prev);
                chk("no_early_done", 64'(o_done(sel)), 64'd0);
            end
            if (o_done(sel)) begin
                lat = c;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(n));
        chk("busy_cycles", 64'(busy_cnt), 64'(n));
        chk("diff", o_diff(sel), ed);
        chk("borrow", 64'(o_bor(sel)), 64'(eb));
        chk("overflow", 64'(o_ovf(sel)), 64'(eo));
        chk("busy_in_done", 64'(o_busy(sel)), 64'd0);
    endtask

    task automatic run_op(input int sel, input int n, input vec_t v);
        @(posedge clk);
        #1;
        a = v.av;
        b = v.bv;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        a = 64'd0;
        b = 64'd0;
        wait_done(sel, n, (sel == 1) ? prev1 : prev8, v.d, v.bor, v.ovf);
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done(sel)), 64'd0);
        if (sel == 1) prev1 = v.d;
        else          prev8 = v.d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        prev1  = 64'd0;
        prev8  = 64'd0;
        rst    = 1'b1;
        start1 = 1'b0;
        start8 = 1'b0;
        a      = 64'd0;
        b      = 64'd0;

        vecs[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b0};
        vecs[5] = '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_diff1", diff1, 64'd0);
        chk("rst_flags8", {62'd0, borrow8, ovf8}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_op(1, 64, vecs[i]);
        for (int i = 0; i < 6; i++) run_op(8, 8, vecs[i]);

        // Handshake: mid-run start is ignored, start in the DONE cycle chains.
        @(posedge clk);
        #1;
        a = 64'd100; b = 64'd40; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 64'd1; b = 64'd1; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("ignored_start_busy", 64'(busy8), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("hs_done", 64'(done8), 64'd1);
        chk("hs_diff", diff8, 64'd60);
        chk("hs_borrow", 64'(borrow8), 64'd0);
        a = 64'd7; b = 64'd9; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a = 64'd0; b = 64'd0;
        wait_done(8, 8, 64'd60, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        prev8 = 64'hFFFF_FFFF_FFFF_FFFE;

        // Reset mid-operation: outputs clear asynchronously, no done follows.
        @(posedge clk);
        #1;
        a = 64'd10; b = 64'd4; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy8), 64'd0);
        chk("arst_done", 64'(done8), 64'd0);
        chk("arst_diff", diff8, 64'd0);
        chk("arst_borrow", 64'(borrow8), 64'd0);
        chk("arst_overflow", 64'(ovf8), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done8 || busy8) seen++;
            end
            chk("no_done_after_abort", 64'(seen), 64'd0);
        end
        prev8 = 64'd0;
        run_op(8, 8, '{64'd10, 64'd4, 64'd6, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
